// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding, default width
// and the counter-width helper.
package sub_pkg;

  localparam int SUB_WIDTH = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Never returns less than 1 so a WIDTH=1 counter still has a bit to hold.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/full_sub.sv
// Combinational 1-bit full subtractor: diff = a - b - bin, with borrow-out.
module full_sub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub.sv
// LSB-first bit-serial subtractor: a - b - bin over WIDTH cycles through a single
// full-subtractor slice, with a start/busy/done handshake and registered outputs.
module serial_sub
  import sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CNT_W = clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res;
  logic             r_brw;
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;

  logic             w_d;
  logic             w_bo;
  logic [WIDTH-1:0] w_res_next;

  full_sub u_full_sub (
    .a    (r_a_sh[0]),
    .b    (r_b_sh[0]),
    .bin  (r_brw),
    .diff (w_d),
    .bout (w_bo)
  );

  // New difference bit enters at the MSB; after WIDTH steps the LSB sits at bit 0.
  assign w_res_next = (r_res >> 1) | (WIDTH'(w_d) << (WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_res   <= '0;
      r_brw   <= 1'b0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_brw   <= bin;
            r_res   <= '0;
            r_cnt   <= '0;
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_a_sh <= r_a_sh >> 1;
          r_b_sh <= r_b_sh >> 1;
          r_brw  <= w_bo;
          r_res  <= w_res_next;
          r_cnt  <= r_cnt + CNT_W'(1);
          // On the last step the fresh bit w_d is also the result's sign bit.
          if (r_cnt == LAST_CNT) begin
            r_diff  <= w_res_next;
            r_bout  <= w_bo;
            r_ovf   <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign diff = r_diff;
  assign bout = r_bout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_sub.sv
// Directed self-checking bench for serial_sub at WIDTH=8 and WIDTH=1.
module tb_serial_sub;

  logic       clk;
  logic       rst;

  logic       start8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       bin8;
  logic       busy8;
  logic       done8;
  logic [7:0] diff8;
  logic       bout8;
  logic       ovf8;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       bin1;
  logic       busy1;
  logic       done1;
  logic [0:0] diff1;
  logic       bout1;
  logic       ovf1;

  int assertCount;
  int failCount;

  serial_sub #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .bin   (bin8),
    .busy  (busy8),
    .done  (done8),
    .diff  (diff8),
    .bout  (bout8),
    .ovf   (ovf8)
  );

  serial_sub #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst   (rst),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .bin   (bin1),
    .busy  (busy1),
    .done  (done1),
    .diff  (diff1),
    .bout  (bout1),
    .ovf   (ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launches one WIDTH=8 operation; returns edges from the accepting edge to done
  // (capped at 40) and the number of sampled cycles with busy high.
  task automatic runOp8(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                        output int edges, output int busyCycles);
    a8 = ia; b8 = ib; bin8 = ibin; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    edges = 0;
    busyCycles = 0;
    while (!done8 && edges < 40) begin
      if (busy8) busyCycles++;
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic runOp1(input logic ia, input logic ib, output int edges);
    a1 = ia; b1 = ib; bin1 = 1'b0; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    edges = 0;
    while (!done1 && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
    #2;
    assertCount++;
    if ({busy8, done8, diff8, bout8, ovf8} !== 12'h000) begin
      failCount++;
      $display("[TB] FAIL reset_w8 got busy=%b done=%b diff=%h bout=%b ovf=%b, want all 0",
               busy8, done8, diff8, bout8, ovf8);
    end
    assertCount++;
    if ({busy1, done1, diff1, bout1, ovf1} !== 5'b00000) begin
      failCount++;
      $display("[TB] FAIL reset_w1 got busy=%b done=%b diff=%b bout=%b ovf=%b, want all 0",
               busy1, done1, diff1, bout1, ovf1);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    assertCount++;
    if ({busy8, done8, diff8, bout8, ovf8} !== 12'h000) begin
      failCount++;
      $display("[TB] FAIL idle_after_reset got busy=%b done=%b diff=%h, want all 0",
               busy8, done8, diff8);
    end
  endtask

  task automatic test_basic();
    int edges;
    int busyCycles;
    runOp8(8'h05, 8'h03, 1'b0, edges, busyCycles);
    assertCount++;
    if (edges !== 8) begin
      failCount++;
      $display("[TB] FAIL basic_latency got %0d edges, want 8", edges);
    end
    assertCount++;
    if (busyCycles !== 8) begin
      failCount++;
      $display("[TB] FAIL basic_busy_cycles got %0d, want 8", busyCycles);
    end
    assertCount++;
    if ({busy8, done8, diff8, bout8, ovf8} !== {1'b0, 1'b1, 8'h02, 1'b0, 1'b0}) begin
      failCount++;
      $display("[TB] FAIL basic_result got busy=%b done=%b diff=%h bout=%b ovf=%b, want 0 1 02 0 0",
               busy8, done8, diff8, bout8, ovf8);
    end
    @(posedge clk); #1;
    assertCount++;
    if ({done8, diff8} !== {1'b0, 8'h02}) begin
      failCount++;
      $display("[TB] FAIL done_one_cycle got done=%b diff=%h, want 0 02", done8, diff8);
    end
  endtask

  task automatic test_borrow();
    int edges;
    int busyCycles;
    runOp8(8'h03, 8'h05, 1'b0, edges, busyCycles);
    assertCount++;
    if ({done8, diff8, bout8, ovf8} !== {1'b1, 8'hFE, 1'b1, 1'b0}) begin
      failCount++;
      $display("[TB] FAIL borrow got done=%b diff=%h bout=%b ovf=%b, want 1 fe 1 0",
               done8, diff8, bout8, ovf8);
    end
  endtask

  task automatic test_overflow();
    int edges;
    int busyCycles;
    runOp8(8'h80, 8'h01, 1'b0, edges, busyCycles);
    assertCount++;
    if ({done8, diff8, bout8, ovf8} !== {1'b1, 8'h7F, 1'b0, 1'b1}) begin
      failCount++;
      $display("[TB] FAIL overflow got done=%b diff=%h bout=%b ovf=%b, want 1 7f 0 1",
               done8, diff8, bout8, ovf8);
    end
    @(posedge clk); #1;
    runOp8(8'h00, 8'h00, 1'b1, edges, busyCycles);
    assertCount++;
    if ({done8, diff8, bout8, ovf8} !== {1'b1, 8'hFF, 1'b1, 1'b0}) begin
      failCount++;
      $display("[TB] FAIL borrow_in got done=%b diff=%h bout=%b ovf=%b, want 1 ff 1 0",
               done8, diff8, bout8, ovf8);
    end
  endtask

  // Ends exactly in the done cycle so test_back_to_back can restart there.
  task automatic test_ignore_start();
    int edges;
    a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    edges = 0;
    while (!done8 && edges < 40) begin
      if (edges == 2) begin
        start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
      end else begin
        start8 = 1'b0;
      end
      @(posedge clk); #1;
      edges++;
    end
    start8 = 1'b0;
    assertCount++;
    if (edges !== 8) begin
      failCount++;
      $display("[TB] FAIL ignore_latency got %0d edges, want 8", edges);
    end
    assertCount++;
    if ({done8, diff8, bout8, ovf8} !== {1'b1, 8'h0F, 1'b0, 1'b0}) begin
      failCount++;
      $display("[TB] FAIL ignore_result got done=%b diff=%h bout=%b ovf=%b, want 1 0f 0 0",
               done8, diff8, bout8, ovf8);
    end
  endtask

  task automatic test_back_to_back();
    int edges;
    start8 = 1'b1; a8 = 8'h20; b8 = 8'h10; bin8 = 1'b0;
    @(posedge clk); #1;
    start8 = 1'b0;
    edges = 1;
    assertCount++;
    if ({busy8, done8} !== 2'b10) begin
      failCount++;
      $display("[TB] FAIL b2b_accept got busy=%b done=%b, want 1 0", busy8, done8);
    end
    while (!done8 && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    assertCount++;
    if (edges !== 9) begin
      failCount++;
      $display("[TB] FAIL b2b_spacing got %0d edges, want 9", edges);
    end
    assertCount++;
    if ({done8, diff8, bout8, ovf8} !== {1'b1, 8'h10, 1'b0, 1'b0}) begin
      failCount++;
      $display("[TB] FAIL b2b_result got done=%b diff=%h bout=%b ovf=%b, want 1 10 0 0",
               done8, diff8, bout8, ovf8);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    int edges;
    int busyCycles;
    bit sawActivity;
    a8 = 8'hC3; b8 = 8'h5A; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    assertCount++;
    if ({busy8, done8, diff8, bout8, ovf8} !== 12'h000) begin
      failCount++;
      $display("[TB] FAIL abort_async got busy=%b done=%b diff=%h bout=%b ovf=%b, want all 0",
               busy8, done8, diff8, bout8, ovf8);
    end
    #2;
    rst = 1'b0;
    sawActivity = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (busy8 || done8) sawActivity = 1'b1;
    end
    assertCount++;
    if (sawActivity !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL abort_quiet got activity=%b after reset, want 0", sawActivity);
    end
    runOp8(8'h09, 8'h04, 1'b0, edges, busyCycles);
    assertCount++;
    if ({done8, diff8, bout8, ovf8} !== {1'b1, 8'h05, 1'b0, 1'b0}) begin
      failCount++;
      $display("[TB] FAIL after_abort got done=%b diff=%h bout=%b ovf=%b, want 1 05 0 0",
               done8, diff8, bout8, ovf8);
    end
  endtask

  task automatic test_width1();
    logic [1:0] vecIn  [4];
    logic [1:0] vecOut [4];
    int edges;
    // Half-subtractor truth table as {a,b} -> {diff,bout}.
    vecIn[0] = 2'b00; vecOut[0] = 2'b00;
    vecIn[1] = 2'b10; vecOut[1] = 2'b10;
    vecIn[2] = 2'b01; vecOut[2] = 2'b11;
    vecIn[3] = 2'b11; vecOut[3] = 2'b00;
    for (int i = 0; i < 4; i++) begin
      runOp1(vecIn[i][1], vecIn[i][0], edges);
      assertCount++;
      if (edges !== 1) begin
        failCount++;
        $display("[TB] FAIL w1_latency ab=%b got %0d edges, want 1", vecIn[i], edges);
      end
      assertCount++;
      if ({diff1, bout1} !== vecOut[i]) begin
        failCount++;
        $display("[TB] FAIL w1_result ab=%b got diff,bout=%b%b, want %b",
                 vecIn[i], diff1, bout1, vecOut[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    assertCount = 0;
    failCount = 0;
    test_reset();
    test_basic();
    test_borrow();
    test_overflow();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_width1();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not complete within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
